// File: rtl/hsv_core_pkg.sv
// Shared core types: common instruction fields, commit record, exception
// causes and the multiply unit's operation/payload types.
package hsv_core_pkg;

    // Fields every execution unit carries from issue to commit untouched.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_increment;
        logic [4:0]  rd_addr;
        logic [7:0]  token;
    } common_data_t;

    typedef enum logic [1:0] {
        COMMIT_NEXT      = 2'd0,
        COMMIT_JUMP      = 2'd1,
        COMMIT_EXCEPTION = 2'd2
    } commit_action_t;

    typedef enum logic [4:0] {
        EXC_INSTRUCTION_MISALIGNED   = 5'd0,
        EXC_INSTRUCTION_ACCESS_FAULT = 5'd1,
        EXC_ILLEGAL_INSTRUCTION      = 5'd2,
        EXC_BREAKPOINT               = 5'd3,
        EXC_HARDWARE_ERROR           = 5'd24
    } exception_cause_t;

    typedef struct packed {
        common_data_t     common;
        commit_action_t   action;
        logic             writeback;
        logic [31:0]      result;
        logic [31:0]      next_pc;
        exception_cause_t exception_cause;
        logic [31:0]      exception_value;
    } commit_data_t;

    // MUL_HSS = MULH, MUL_HSU = MULHSU, MUL_HUU = MULHU.
    typedef enum logic [1:0] {
        MUL_LO  = 2'd0,
        MUL_HSS = 2'd1,
        MUL_HSU = 2'd2,
        MUL_HUU = 2'd3
    } mul_op_t;

    typedef struct packed {
        common_data_t common;
        mul_op_t      op;
        logic [31:0]  rs1_value;
        logic [31:0]  rs2_value;
    } mul_data_t;

    // Payload travelling down the multiply pipe after the product is formed.
    typedef struct packed {
        common_data_t common;
        mul_op_t      op;
        logic [63:0]  product;
    } mul_stage_t;

    // True for the ops that return the upper half of the product.
    function automatic logic mul_is_high(input mul_op_t op);
        return (op != MUL_LO);
    endfunction

endpackage

// File: rtl/hsv_core_mul_stage.sv
// One register stage of the multiply pipe: payload plus valid, frozen by
// the global stall and emptied by flush.
module hsv_core_mul_stage
    import hsv_core_pkg::*;
(
    input  logic       clk_core,
    input  logic       rst_core_n,
    input  logic       stall,
    input  logic       flush,
    input  logic       in_valid,
    input  mul_stage_t in_data,
    output logic       out_valid,
    output mul_stage_t out_data
);

    logic       valid_r;
    mul_stage_t data_r;

    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Stage valid: flush beats stall, stall holds, otherwise advance.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (!stall) begin
            valid_r <= in_valid;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Stage payload advances whenever the pipe is not stalled.
    always_ff @(posedge clk_core) begin
        if (!stall) begin
            data_r <= in_data;
        end
    end

endmodule

// File: rtl/hsv_core_skid_buffer.sv
// Two-entry skid buffer between an execution unit and commit. The upstream
// ready is a register (empty skid slot), so it never depends on the
// downstream ready combinationally.
module hsv_core_skid_buffer
    import hsv_core_pkg::*;
(
    input  logic         clk_core,
    input  logic         rst_core_n,
    input  logic         flush,
    input  commit_data_t in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output commit_data_t out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         out_valid_r;
    logic         skid_valid_r;
    commit_data_t out_data_r;
    commit_data_t skid_data_r;

    logic out_valid_n_s;
    logic skid_valid_n_s;
    logic load_out_s;
    logic load_skid_s;
    logic out_from_skid_s;

    assign in_ready  = ~skid_valid_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Next-state decision for the output and skid slots.
    always_comb begin
        out_valid_n_s   = out_valid_r;
        skid_valid_n_s  = skid_valid_r;
        load_out_s      = 1'b0;
        load_skid_s     = 1'b0;
        out_from_skid_s = 1'b0;
        if (flush) begin
            out_valid_n_s  = 1'b0;
            skid_valid_n_s = 1'b0;
        end else if (out_valid_r && !out_ready) begin
            if (in_valid && !skid_valid_r) begin
                skid_valid_n_s = 1'b1;
                load_skid_s    = 1'b1;
            end else begin
                skid_valid_n_s = skid_valid_r;
            end
        end else if (skid_valid_r) begin
            out_valid_n_s   = 1'b1;
            skid_valid_n_s  = 1'b0;
            out_from_skid_s = 1'b1;
        end else begin
            out_valid_n_s = in_valid;
            load_out_s    = in_valid;
        end
    end

    // Slot valid flags; reset and flush empty both slots.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            out_valid_r  <= 1'b0;
            skid_valid_r <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
        end
    end

    // Slot payloads; not reset since they are qualified by the valid flags.
    always_ff @(posedge clk_core) begin
        if (out_from_skid_s) begin
            out_data_r <= skid_data_r;
        end else if (load_out_s) begin
            out_data_r <= in_data;
        end
        if (load_skid_s) begin
            skid_data_r <= in_data;
        end
    end

endmodule

// File: rtl/hsv_core_mul.sv
// RV32M multiply execution unit (MUL/MULH/MULHSU/MULHU) with a
// STAGES-deep stall/flush-aware pipe feeding a commit skid buffer.
module hsv_core_mul
    import hsv_core_pkg::*;
#(
    parameter int unsigned STAGES  = 2,
    parameter bit          HIGH_EN = 1'b1
) (
    input  logic         clk_core,
    input  logic         rst_core_n,
    input  logic         flush_req,
    output logic         flush_ack,
    input  mul_data_t    mul_data,
    output logic         ready_o,
    input  logic         valid_i,
    output commit_data_t commit_data,
    input  logic         ready_i,
    output logic         valid_o
);

    logic out_ready_s;
    logic stall_s;

    logic        rs1_signed_s;
    logic        rs2_signed_s;
    logic [63:0] rs1_ext_s;
    logic [63:0] rs2_ext_s;
    mul_stage_t  s1_data_s;

    logic       s1_valid_r;
    mul_stage_t s1_data_r;

    logic       [STAGES-1:0] pipe_valid_s;
    mul_stage_t [STAGES-1:0] pipe_data_s;

    mul_stage_t   last_s;
    commit_data_t commit_s;

    assign stall_s = ~out_ready_s;
    assign ready_o = ~stall_s;

    // Operand extension and product. Only the low 64 bits of the 33x33
    // product are ever observed, so the operands are extended straight to
    // 64 bits and the multiply is done modulo 2^64.
    always_comb begin
        rs1_signed_s = (mul_data.op == MUL_HSS) || (mul_data.op == MUL_HSU);
        rs2_signed_s = (mul_data.op == MUL_HSS);
        rs1_ext_s    = {{32{rs1_signed_s & mul_data.rs1_value[31]}}, mul_data.rs1_value};
        rs2_ext_s    = {{32{rs2_signed_s & mul_data.rs2_value[31]}}, mul_data.rs2_value};
        s1_data_s.common  = mul_data.common;
        s1_data_s.op      = mul_data.op;
        s1_data_s.product = rs1_ext_s * rs2_ext_s;
    end

    // Stage 1 valid: accepts when ready; flush drops the incoming op.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            s1_valid_r <= 1'b0;
        end else if (flush_req) begin
            s1_valid_r <= 1'b0;
        end else if (!stall_s) begin
            s1_valid_r <= valid_i;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 1 payload captures the freshly formed product.
    always_ff @(posedge clk_core) begin
        if (!stall_s) begin
            s1_data_r <= s1_data_s;
        end
    end

    assign pipe_valid_s[0] = s1_valid_r;
    assign pipe_data_s[0]  = s1_data_r;

    for (genvar g = 1; g < STAGES; g++) begin : g_stage
        hsv_core_mul_stage u_stage (
            .clk_core   (clk_core),
            .rst_core_n (rst_core_n),
            .stall      (stall_s),
            .flush      (flush_req),
            .in_valid   (pipe_valid_s[g-1]),
            .in_data    (pipe_data_s[g-1]),
            .out_valid  (pipe_valid_s[g]),
            .out_data   (pipe_data_s[g])
        );
    end

    assign last_s = pipe_data_s[STAGES-1];

    // Result select and commit record; high-half ops trap when disabled.
    always_comb begin
        commit_s.common          = last_s.common;
        commit_s.next_pc         = last_s.common.pc_increment;
        commit_s.exception_value = 32'd0;
        if (mul_is_high(last_s.op) && (HIGH_EN == 1'b0)) begin
            commit_s.action          = COMMIT_EXCEPTION;
            commit_s.exception_cause = EXC_ILLEGAL_INSTRUCTION;
            commit_s.writeback       = 1'b0;
            commit_s.result          = 32'd0;
        end else begin
            commit_s.action          = COMMIT_NEXT;
            commit_s.exception_cause = EXC_HARDWARE_ERROR;
            commit_s.writeback       = 1'b1;
            commit_s.result          = mul_is_high(last_s.op) ? last_s.product[63:32]
                                                              : last_s.product[31:0];
        end
    end

    // Flush acknowledge follows the request by one cycle; high in reset.
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            flush_ack <= 1'b1;
        end else begin
            flush_ack <= flush_req;
        end
    end

    hsv_core_skid_buffer u_skid (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .flush      (flush_req),
        .in_data    (commit_s),
        .in_valid   (pipe_valid_s[STAGES-1]),
        .in_ready   (out_ready_s),
        .out_data   (commit_data),
        .out_valid  (valid_o),
        .out_ready  (ready_i)
    );

endmodule

// File: tb/tb_hsv_core_mul.sv
// Bench for hsv_core_mul: main instance (STAGES=2, HIGH_EN=1) checked by a
// scoreboard, plus STAGES=1 and STAGES=4 instances with HIGH_EN=0.
module tb_hsv_core_mul;
    import hsv_core_pkg::*;

    localparam int S = 2;

    logic clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic         rst_core_n;
    logic         flush_req, flush_ack, ready_o, valid_i, ready_i, valid_o;
    mul_data_t    mul_data;
    commit_data_t commit_data;

    logic         a_valid_i, a_ready_i, a_flush_req;
    mul_data_t    a_data;
    logic         a1_flush_ack, a1_ready_o, a1_valid_o;
    logic         a4_flush_ack, a4_ready_o, a4_valid_o;
    commit_data_t a1_commit, a4_commit;

    int total = 0;
    int bad = 0;
    int out_count = 0;
    commit_data_t exp_q[$];

    hsv_core_mul #(.STAGES(S), .HIGH_EN(1'b1)) dut (
        .clk_core(clk_core), .rst_core_n(rst_core_n), .flush_req(flush_req),
        .flush_ack(flush_ack), .mul_data(mul_data), .ready_o(ready_o),
        .valid_i(valid_i), .commit_data(commit_data), .ready_i(ready_i),
        .valid_o(valid_o));

    hsv_core_mul #(.STAGES(1), .HIGH_EN(1'b0)) dut_s1 (
        .clk_core(clk_core), .rst_core_n(rst_core_n), .flush_req(a_flush_req),
        .flush_ack(a1_flush_ack), .mul_data(a_data), .ready_o(a1_ready_o),
        .valid_i(a_valid_i), .commit_data(a1_commit), .ready_i(a_ready_i),
        .valid_o(a1_valid_o));

    hsv_core_mul #(.STAGES(4), .HIGH_EN(1'b0)) dut_s4 (
        .clk_core(clk_core), .rst_core_n(rst_core_n), .flush_req(a_flush_req),
        .flush_ack(a4_flush_ack), .mul_data(a_data), .ready_o(a4_ready_o),
        .valid_i(a_valid_i), .commit_data(a4_commit), .ready_i(a_ready_i),
        .valid_o(a4_valid_o));

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input mul_op_t op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            MUL_HSS: p = sa * sb;
            MUL_HSU: p = sa * ub;
            default: p = ua * ub;
        endcase
        return (op == MUL_LO) ? p[31:0] : p[63:32];
    endfunction

    function automatic mul_data_t mk(input mul_op_t op, input logic [31:0] a,
                                     input logic [31:0] b, input int tag);
        mul_data_t d;
        d.common.pc           = 32'h0000_1000 + 32'(tag) * 32'd4;
        d.common.pc_increment = d.common.pc + 32'd4;
        d.common.rd_addr      = 5'(tag);
        d.common.token        = 8'(tag);
        d.op                  = op;
        d.rs1_value           = a;
        d.rs2_value           = b;
        return d;
    endfunction

    function automatic commit_data_t exp_commit(input mul_data_t d, input logic [31:0] res);
        commit_data_t c;
        c.common          = d.common;
        c.action          = COMMIT_NEXT;
        c.writeback       = 1'b1;
        c.result          = res;
        c.next_pc         = d.common.pc_increment;
        c.exception_cause = EXC_HARDWARE_ERROR;
        c.exception_value = 32'd0;
        return c;
    endfunction

    // Called at a negedge; waits for ready_o, drives one op, returns at the next negedge.
    task automatic send(input mul_data_t d, input bit keep, input logic [31:0] res);
        int guard = 0;
        while (!ready_o && guard < 50) begin
            @(negedge clk_core);
            guard++;
        end
        if (guard >= 50) check("send_ready_timeout", guard, 0);
        mul_data = d;
        valid_i  = 1'b1;
        if (keep) exp_q.push_back(exp_commit(d, res));
        @(negedge clk_core);
        valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(negedge clk_core);
            #2;
            guard++;
        end
        check(tag, exp_q.size(), 0);
        @(negedge clk_core);
    endtask

    task automatic aux_run(input mul_data_t d, output int l1, output int l4,
                           output commit_data_t c1, output commit_data_t c4);
        int n;
        l1 = 0;
        l4 = 0;
        c1 = '0;
        c4 = '0;
        a_data    = d;
        a_valid_i = 1'b1;
        @(posedge clk_core);
        #1;
        a_valid_i = 1'b0;
        n = 1;
        while ((l1 == 0 || l4 == 0) && n < 20) begin
            if (l1 == 0 && a1_valid_o) begin l1 = n; c1 = a1_commit; end
            if (l4 == 0 && a4_valid_o) begin l4 = n; c4 = a4_commit; end
            @(posedge clk_core);
            #1;
            n++;
        end
        @(negedge clk_core);
    endtask

    // Scoreboard: every handshaken output must match the oldest expected record.
    always @(negedge clk_core) begin
        #1;
        if (rst_core_n && valid_o && ready_i) begin
            out_count++;
            check("sb_output_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                check("sb_commit", commit_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        mul_data_t    d;
        commit_data_t c1, c4;
        int           lat, l1, l4, issued, cnt_before;

        rst_core_n  = 1'b0;
        flush_req   = 1'b0;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        mul_data    = '0;
        a_valid_i   = 1'b0;
        a_ready_i   = 1'b1;
        a_flush_req = 1'b0;
        a_data      = '0;

        #12;
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_flush_ack", flush_ack, 1'b1);
        check("rst_ready_o", ready_o, 1'b1);
        check("rst_aux_valid", {a1_valid_o, a4_valid_o}, 2'b00);
        @(negedge clk_core);
        rst_core_n = 1'b1;
        repeat (2) @(negedge clk_core);
        check("ack_idle", flush_ack, 1'b0);

        // MUL latency and result
        d = mk(MUL_LO, 32'd7, 32'hFFFF_FFFD, 1);
        check("ready_idle", ready_o, 1'b1);
        mul_data = d;
        valid_i  = 1'b1;
        exp_q.push_back(exp_commit(d, 32'hFFFF_FFEB));
        @(posedge clk_core);
        #1;
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(posedge clk_core);
            #1;
            lat++;
        end
        check("mul_latency", lat, S + 1);
        @(negedge clk_core);
        drain("drain_mul");

        // High-half directed cases
        send(mk(MUL_HSS, 32'h8000_0000, 32'h8000_0000, 2), 1'b1, 32'h4000_0000);
        send(mk(MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3), 1'b1, 32'hFFFF_FFFE);
        send(mk(MUL_HSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4), 1'b1, 32'hFFFF_FFFF);
        drain("drain_high");

        // Stream of 8 with ready_i low for 3 cycles
        cnt_before = out_count;
        issued = 0;
        for (int cyc = 0; cyc < 40 && issued < 8; cyc++) begin
            ready_i = !(cyc >= 3 && cyc <= 5);
            if (cyc == 5) check("ready_low_stall", ready_o, 1'b0);
            if (ready_o) begin
                d = mk(mul_op_t'(2'(issued)), $urandom(), $urandom(), 10 + issued);
                if (issued == 0) begin
                    d.rs1_value = 32'h7FFF_FFFF;
                    d.rs2_value = 32'h8000_0000;
                end
                mul_data = d;
                valid_i  = 1'b1;
                exp_q.push_back(exp_commit(d, model_result(d.op, d.rs1_value, d.rs2_value)));
                issued++;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_core);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        drain("drain_stream");
        check("stream_count", out_count - cnt_before, 8);

        // Flush with a full pipe
        cnt_before = out_count;
        send(mk(MUL_LO, 32'd3, 32'd5, 30), 1'b0, 32'd0);
        send(mk(MUL_HUU, 32'd9, 32'd9, 31), 1'b0, 32'd0);
        flush_req = 1'b1;
        #1;
        check("ack_before_edge", flush_ack, 1'b0);
        @(negedge clk_core);
        mul_data = mk(MUL_LO, 32'd11, 32'd13, 32);
        valid_i  = 1'b1;
        #1;
        check("ack_rise", flush_ack, 1'b1);
        check("flush_valid_o_a", valid_o, 1'b0);
        @(negedge clk_core);
        valid_i   = 1'b0;
        flush_req = 1'b0;
        #1;
        check("ack_hold", flush_ack, 1'b1);
        check("flush_valid_o_b", valid_o, 1'b0);
        @(negedge clk_core);
        #1;
        check("ack_fall", flush_ack, 1'b0);
        repeat (5) @(negedge clk_core);
        check("flush_no_output", out_count - cnt_before, 0);
        d = mk(MUL_LO, 32'h0001_0000, 32'h0001_0001, 33);
        send(d, 1'b1, 32'h0001_0000);
        drain("drain_post_flush");
        check("post_flush_count", out_count - cnt_before, 1);

        // Reset with ops in flight
        cnt_before = out_count;
        ready_i = 1'b0;
        send(mk(MUL_LO, 32'd2, 32'd2, 40), 1'b0, 32'd0);
        send(mk(MUL_LO, 32'd4, 32'd4, 41), 1'b0, 32'd0);
        repeat (3) @(negedge clk_core);
        #1;
        check("stuck_valid", valid_o, 1'b1);
        rst_core_n = 1'b0;
        #1;
        check("midrst_valid_o", valid_o, 1'b0);
        check("midrst_flush_ack", flush_ack, 1'b1);
        repeat (2) @(negedge clk_core);
        rst_core_n = 1'b1;
        ready_i    = 1'b1;
        repeat (6) @(negedge clk_core);
        check("no_stale_after_rst", out_count - cnt_before, 0);
        send(mk(MUL_HSS, 32'hFFFF_FFFF, 32'h0000_0002, 42), 1'b1, 32'hFFFF_FFFF);
        drain("drain_post_rst");

        // HIGH_EN=0 instances, STAGES=1 and 4
        check("aux_ready", {a1_ready_o, a4_ready_o}, 2'b11);
        aux_run(mk(MUL_HUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 50), l1, l4, c1, c4);
        check("s1_latency", l1, 2);
        check("s4_latency", l4, 5);
        check("s1_exc_action", c1.action, COMMIT_EXCEPTION);
        check("s1_exc_cause", c1.exception_cause, EXC_ILLEGAL_INSTRUCTION);
        check("s1_exc_wb", c1.writeback, 1'b0);
        check("s1_exc_result", c1.result, 32'd0);
        check("s4_exc_action", c4.action, COMMIT_EXCEPTION);
        check("s4_exc_cause", c4.exception_cause, EXC_ILLEGAL_INSTRUCTION);
        check("s4_exc_wb", c4.writeback, 1'b0);
        aux_run(mk(MUL_LO, 32'd5, 32'hFFFF_FFFA, 51), l1, l4, c1, c4);
        check("s1_mul_latency", l1, 2);
        check("s4_mul_latency", l4, 5);
        check("s1_mul_result", {c1.action, c1.writeback, c1.result}, {COMMIT_NEXT, 1'b1, 32'hFFFF_FFE2});
        check("s4_mul_result", {c4.action, c4.writeback, c4.result}, {COMMIT_NEXT, 1'b1, 32'hFFFF_FFE2});
        check("s4_next_pc", c4.next_pc, 32'h0000_1000 + 32'd51 * 32'd4 + 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hsv_core_mul.md
Name: hsv_core_mul

Overview:
- Parametrised, pipelined integer multiply execution unit for the RV32 M-extension multiply ops: MUL, MULH, MULHSU, MULHU.
- Sits beside ALU/branch/mem between issue and commit, using the standard execution-unit contract: ready/valid sink, commit skid buffer source, flush req/ack.
- Generalises the single-stage unit template to a configurable STAGES-deep pipe with per-stage valids.
- Optional high-half support; unsupported ops raise an exception.

Parameters:
- STAGES, default 2: pipeline register stages before the skid buffer. Legal range 1..4.
- HIGH_EN, default 1: 1 means MULH/MULHSU/MULHU are implemented; 0 means they commit as illegal instruction.

Ports:
- clk_core  in  1  core clock
- rst_core_n  in  1  asynchronous active-low reset
- flush_req  in  1  flush request from the control unit
- flush_ack  out  1  flush acknowledge
- mul_data  in  $bits(mul_data_t)  operation: common, op (mul_op_t), rs1_value[31:0], rs2_value[31:0]
- ready_o  out  1  sink ready
- valid_i  in  1  sink valid
- commit_data  out  $bits(commit_data_t)  result to the commit stage
- ready_i  in  1  commit ready
- valid_o  out  1  commit valid

Behaviour:
- Reset (async): all stage valids = 0, flush_ack = 1, valid_o = 0 (skid buffer reset). Datapath registers are not reset.
- Stall: stall = ~out_ready, where out_ready is the skid buffer's ready_o. ready_o = ~stall.
  - The stall freezes all stages globally. No bubble collapsing.
- Transfer: an op is accepted on a clock edge where valid_i & ready_o.
- Latency: with ready_i held high, valid_o asserts STAGES+1 cycles after acceptance. The skid buffer adds 1 cycle.
  - Throughput: 1 op/cycle.
- Stage 1: extend operands to 33 bits.
  - rs1 is sign-extended for MULH/MULHSU.
  - rs2 is sign-extended for MULH only.
  - Zero-extend in all other cases.
  - Form the 66-bit signed product. Stages 2..STAGES carry the product, op and common unchanged; retiming is permitted.
- Final stage selects result: MUL = product[31:0], all MULH* = product[63:32].
- Commit fields:
  - action = COMMIT_NEXT, writeback = 1, next_pc = common.pc_increment, common passed through untouched.
  - exception_cause = EXC_HARDWARE_ERROR (ignored), exception_value = 0.
- HIGH_EN=0 with a MULH* op: action = COMMIT_EXCEPTION, exception_cause = EXC_ILLEGAL_INSTRUCTION, writeback = 0, result = 0.
- Flush:
  - On any edge with flush_req = 1, all stage valids clear and the input is dropped.
  - Flush has priority over stall and valid_i.
  - The skid buffer flush input is tied to flush_req.
  - flush_ack <= flush_req, registered, so ack follows req by exactly one cycle in both directions and never flips before req.
- Boundary cases:
  - valid_i during stall is held off by ready_o = 0. The pipe contents never change while stalled.
  - Stall and flush on the same edge: the flush wins.
  - Reset mid-flight discards everything. No output appears until new ops are accepted.
  - STAGES=1 degenerates to the single-stage template timing.
  - rd = x0 needs no special case; commit handles it.

Decomposition:
- hsv_core_pkg additions:
  - mul_op_t enum: MUL_LO, MUL_HSS, MUL_HSU, MUL_HUU.
  - mul_data_t struct: common, op, rs1_value, rs2_value.
  - EXC_ILLEGAL_INSTRUCTION, if not already present.
- Reuse hsv_core_skid_buffer for the output.
- One local sub-module, hsv_core_mul_stage: one stall/flush-aware payload+valid register, instantiated STAGES-1 times via generate.

Test Plan:
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD -> result 0xFFFFFFEB, writeback = 1, action COMMIT_NEXT, valid_o exactly STAGES+1 cycles after acceptance.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- Stream 8 back-to-back ops, drop ready_i for 3 cycles mid-stream -> ready_o low while stalled, all 8 results in order, no duplicates or losses.
- Fill the pipe with STAGES ops, pulse flush_req for 2 cycles -> flush_ack rises 1 cycle after req and falls 1 cycle after req falls, no flushed op reaches valid_o, the next op completes normally.
- Assert rst_core_n low with ops in flight -> valid_o = 0 and flush_ack = 1 immediately, with no stale result after release.
- HIGH_EN = 0, issue MULHU -> action COMMIT_EXCEPTION, cause EXC_ILLEGAL_INSTRUCTION, writeback = 0. Repeat for STAGES = 1 and STAGES = 4.
